// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with valid/ready handshake,
// synchronous active-high reset, stall back-pressure and flush/bubble insertion.
// Control bits are zeroed on every bubble; data bits hold their last value.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : two-slot stage (main + skid), in_ready depends only on state
//   undefined : single-slot stage, in_ready combinational from out_ready
//
// Ports:
//   clk       stage clock, rising edge
//   rst       synchronous active-high reset
//   flush     kill slot contents and the beat offered this cycle
//   in_valid  upstream beat present
//   in_ready  stage accepts a beat this cycle
//   in_ctrl   upstream control field (CTRL_W)
//   in_data   upstream data field (DATA_W)
//   out_valid downstream beat present (registered)
//   out_ready downstream accepts the beat
//   out_ctrl  registered control field, 0 whenever out_valid=0
//   out_data  registered data field, holds when out_valid=0
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic main_free;
  logic accept;

  // Main slot can take a new beat when it is empty or emitting this edge.
  assign main_free = ~out_valid | out_ready;
  // A beat offered during flush is discarded even if in_ready=1.
  assign accept    = in_valid & in_ready & ~flush;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready = ~skid_valid & ~rst;

  // Main + skid slot update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Skid beat is older than anything upstream; in_ready=0 so no accept.
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end else if (accept) begin
      // Main is full and stalled: park the new beat in the skid slot.
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end

`else

  assign in_ready = main_free & ~rst;

  // Single main slot update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (main_free) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue-based occupancy model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned DATA_W = 80;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity CAP; the head is what out_* shows.
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;
  beat_t q[$];
  logic [DATA_W-1:0] m_last = '0;

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (CAP == 1) return (q.size() == 0) || out_ready;
    return q.size() < CAP;
  endfunction

  always @(posedge clk) begin
    bit rdy;
    rdy = m_ready();
    if (rst) begin
      q.delete();
      m_last = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back('{c: in_ctrl, d: in_data});
    end
    if (q.size() > 0) m_last = q[0].d;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid", out_valid, q.size() > 0);
      check("m_out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
      check("m_out_data", out_data, m_last);
      check("m_in_ready", in_ready, m_ready());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 4'hF;
    in_data = 80'hDEAD; out_ready = 1'b1;

    // Reset held for 3 cycles with a beat offered
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Streaming 1..8, no bubbles
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 4'h5; in_data = DATA_W'(i);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_ctrl", out_ctrl, 4'h5);
      check("stream_data", out_data, i);
    end
    in_valid = 1'b0;
    tick();

    // Bubble after 0x77 beat
    in_valid = 1'b1; in_ctrl = 4'h9; in_data = 80'h77;
    tick();
    check("bub_first", out_data, 80'h77);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bub_valid", out_valid, 0);
      check("bub_ctrl", out_ctrl, 0);
      check("bub_data", out_data, 80'h77);
    end

    // Stall: A5 held while B6 is offered
    in_valid = 1'b1; in_ctrl = 4'h2; in_data = 80'hA5;
    tick();
    check("stall_load", out_data, 80'hA5);
    out_ready = 1'b0; in_ctrl = 4'h6; in_data = 80'hB6;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef PIPE_STAGE_SKID_EN
      check("stall_in_ready", in_ready, (i == 0 && in_valid) ? 1 : 0);
`else
      check("stall_in_ready", in_ready, 0);
`endif
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 80'hA5);
      check("stall_ctrl", out_ctrl, 4'h2);
    end
    out_ready = 1'b1;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    check("release_in_ready", in_ready, 0);
`else
    check("release_in_ready", in_ready, 1);
`endif
    tick();
    in_valid = 1'b0;
    check("release_data", out_data, 80'hB6);
    check("release_ctrl", out_ctrl, 4'h6);
    tick();
    check("release_drain", out_valid, 0);

    // Flush with a held beat and a second beat offered
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'h3; in_data = 80'h33;
    tick();
    check("flush_load", out_ctrl, 4'h3);
    in_ctrl = 4'h6; in_data = 80'h44; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_data", out_data, 80'h33);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_gone", out_valid, 0);
    end

    // Mid-stall reset with both slots (where present) full
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'hC; in_data = 80'hC1;
    tick();
    in_ctrl = 4'hD; in_data = 80'hC2;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_ctrl", out_ctrl, 0);
    check("mrst_data", out_data, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_stale", out_valid, 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
